// File: rtl/audio_nios_key_debounced.sv
// Debounced key/switch input port with a small memory-mapped register file.
// Each input is synchronised, then debounced: a new level is accepted only
// after it has persisted for DEBOUNCE_CYCLES clocks. Accepted edges are
// latched into edge_capture, and irq is raised for any unmasked captured bit.
//
// Register map (3-bit address, unused upper data bits read 0):
//   0 stable (RO)  1 sync raw (RO)  2 irq_mask (RW)
//   3 edge_capture (R / write-1-to-clear)  4 rise_en (RW)  5 fall_en (RW)
//   6, 7 read 0, writes ignored
module audio_nios_key_debounced #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_capture;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;

  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge_set;
  logic [WIDTH-1:0] w_edge_clr;
  logic             w_wr;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  // Only the low WIDTH bits of writedata are meaningful.
  assign w_unused_wdata = ^writedata;

  // Two-flop synchroniser for the asynchronous key inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: every cycle the synchronised value is accepted.
      assign w_accept = '1;
    end else begin : g_debounce
      localparam int             CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0]  TC = CW'(DEBOUNCE_CYCLES - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] r_cnt;
        // Accept the new level on the edge where the count of differing
        // cycles hits its terminal value; any agreement restarts the count.
        assign w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt == TC);

        // Per-bit persistence counter: runs while sync differs from stable.
        always_ff @(posedge clk) begin
          if (reset) begin
            r_cnt <= '0;
          end else if ((r_sync2[i] == r_stable[i]) || (r_cnt == TC)) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end
  endgenerate

  // Debounced level and its one-cycle delayed copy; keys idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable   <= '1;
      r_stable_d <= '1;
    end else begin
      r_stable   <= (r_stable & ~w_accept) | (r_sync2 & w_accept);
      r_stable_d <= r_stable;
    end
  end

  assign w_rise     = r_stable & ~r_stable_d;
  assign w_fall     = ~r_stable & r_stable_d;
  assign w_edge_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_wr       = chipselect & ~write_n;
  assign w_edge_clr = (w_wr && (address == 3'd3)) ? writedata[WIDTH-1:0] : '0;

  // Control registers and edge capture; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_mask     <= '0;
      r_edge_capture <= '0;
      r_rise_en      <= '0;
      r_fall_en      <= '1;
    end else begin
      r_edge_capture <= (r_edge_capture & ~w_edge_clr) | w_edge_set;
      if (w_wr) begin
        case (address)
          3'd2:    r_irq_mask <= writedata[WIDTH-1:0];
          3'd4:    r_rise_en  <= writedata[WIDTH-1:0];
          3'd5:    r_fall_en  <= writedata[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  // Address-selected read mux, zero-extended to the bus width.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      3'd0:    w_rd_mux[WIDTH-1:0] = r_stable;
      3'd1:    w_rd_mux[WIDTH-1:0] = r_sync2;
      3'd2:    w_rd_mux[WIDTH-1:0] = r_irq_mask;
      3'd3:    w_rd_mux[WIDTH-1:0] = r_edge_capture;
      3'd4:    w_rd_mux[WIDTH-1:0] = r_rise_en;
      3'd5:    w_rd_mux[WIDTH-1:0] = r_fall_en;
      default: w_rd_mux = '0;
    endcase
  end

  // Read data is registered every cycle regardless of chipselect.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  assign irq = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_audio_nios_key_debounced.sv
// Bench for audio_nios_key_debounced (WIDTH=4, DEBOUNCE_CYCLES=4): directed
// scenarios with literal expectations, then randomized traffic checked every
// cycle against a run-length behavioural model.
module tb_audio_nios_key_debounced;

  localparam int W  = 4;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int tests = 0;
  int fails = 0;

  audio_nios_key_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic         m_valid = 1'b0;
  logic [W-1:0] m_s1, m_s2, m_stable, m_prev, m_mask, m_cap, m_rise, m_fall;
  logic [31:0]  m_rd;
  int           m_run [W];

  // Model: levels are accepted after DC consecutive differing sync samples.
  always @(posedge clk) begin : mdl
    logic [W-1:0] set_v;
    logic [W-1:0] clr_v;
    logic [31:0]  rd_v;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '1; m_prev = '1;
      m_mask = '0; m_cap = '0; m_rise = '0; m_fall = '1; m_rd = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_valid = 1'b1;
    end else begin
      rd_v = 32'd0;
      case (address)
        3'd0: rd_v = 32'(m_stable);
        3'd1: rd_v = 32'(m_s2);
        3'd2: rd_v = 32'(m_mask);
        3'd3: rd_v = 32'(m_cap);
        3'd4: rd_v = 32'(m_rise);
        3'd5: rd_v = 32'(m_fall);
        default: rd_v = 32'd0;
      endcase
      set_v = '0;
      for (int i = 0; i < W; i++)
        if (m_stable[i] != m_prev[i])
          set_v[i] = m_stable[i] ? m_rise[i] : m_fall[i];
      clr_v = '0;
      if (chipselect && !write_n) begin
        case (address)
          3'd2: m_mask = writedata[W-1:0];
          3'd3: clr_v  = writedata[W-1:0];
          3'd4: m_rise = writedata[W-1:0];
          3'd5: m_fall = writedata[W-1:0];
          default: ;
        endcase
      end
      m_cap  = (m_cap & ~clr_v) | set_v;
      m_prev = m_stable;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] != m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= DC) begin
            m_stable[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = in_port;
      m_rd = rd_v;
    end
  end

  // Compare DUT outputs with the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (readdata !== m_rd) begin
        fails++;
        $display("FAIL model_readdata t=%0t: got 0x%08h expected 0x%08h", $time, readdata, m_rd);
      end
      tests++;
      if (irq !== |(m_cap & m_mask)) begin
        fails++;
        $display("FAIL model_irq t=%0t: got %0b expected %0b", $time, irq, |(m_cap & m_mask));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; in_port = 4'hF;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();

    // Reset values
    bus_read(3'd5, rd); check("rst_fall_en", rd, 32'h0000000F);
    bus_read(3'd0, rd); check("rst_stable", rd, 32'h0000000F);
    bus_read(3'd3, rd); check("rst_edge_cap", rd, 32'h00000000);
    check("rst_irq", 32'(irq), 32'd0);

    // Key press on bit 0: accepted exactly 6 cycles after the input change
    bus_write(3'd2, 32'h1);
    address = 3'd0;
    in_port = 4'hE;
    repeat (6) tick();
    check("press_not_yet", readdata, 32'h0000000F);
    tick();
    check("press_stable", readdata, 32'h0000000E);
    check("press_irq", 32'(irq), 32'd1);
    repeat (3) tick();
    bus_read(3'd3, rd); check("press_cap", rd, 32'h00000001);

    // Glitch of 3 cycles on bit 1 is rejected
    bus_write(3'd3, 32'hF);
    bus_read(3'd3, rd); check("w1c_cleared", rd, 32'h0);
    check("w1c_irq", 32'(irq), 32'd0);
    in_port = 4'hC;
    repeat (3) tick();
    in_port = 4'hE;
    repeat (10) tick();
    bus_read(3'd0, rd); check("glitch_stable", rd, 32'h0000000E);
    bus_read(3'd3, rd); check("glitch_cap", rd, 32'h0);

    // Clear and new fall in the same cycle: the event is kept
    in_port = 4'hF; repeat (10) tick();
    in_port = 4'hE; repeat (10) tick();
    bus_read(3'd3, rd); check("refall_cap", rd, 32'h1);
    in_port = 4'hF; repeat (10) tick();
    in_port = 4'hE;
    repeat (6) tick();
    address = 3'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    bus_read(3'd3, rd); check("clr_set_race_cap", rd, 32'h1);
    check("clr_set_race_irq", 32'(irq), 32'd1);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd); check("w1c_alone", rd, 32'h0);

    // Rise-only enable on bit 2
    bus_write(3'd4, 32'h4);
    bus_write(3'd5, 32'h0);
    bus_write(3'd3, 32'hF);
    in_port = 4'hA; repeat (10) tick();
    bus_read(3'd3, rd); check("fall_disabled", rd, 32'h0);
    in_port = 4'hE; repeat (10) tick();
    bus_read(3'd3, rd); check("rise_cap", rd, 32'h4);
    in_port = 4'hA; repeat (10) tick();
    bus_read(3'd3, rd); check("rise_then_fall", rd, 32'h4);
    bus_write(3'd4, 32'h0);
    bus_read(3'd3, rd); check("en_change_keeps", rd, 32'h4);

    // Reset in the middle of a bit-3 debounce
    in_port = 4'hF; repeat (10) tick();
    in_port = 4'h7;
    repeat (4) tick();
    reset = 1'b1; in_port = 4'hF;
    repeat (2) tick();
    reset = 1'b0;
    bus_read(3'd0, rd); check("midrst_stable", rd, 32'h0000000F);
    bus_read(3'd3, rd); check("midrst_cap", rd, 32'h0);
    check("midrst_irq", 32'(irq), 32'd0);
    repeat (10) tick();
    bus_read(3'd3, rd); check("midrst_cap_late", rd, 32'h0);

    // Randomized traffic, checked each cycle by the model comparator
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
      address    = 3'($urandom);
      chipselect = ($urandom_range(0, 2) == 0);
      write_n    = ($urandom_range(0, 1) == 0);
      writedata  = $urandom;
      reset      = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_nios_key_debounced.md
AUDIO_NIOS_KEY_DEBOUNCED -- requirements
Module: audio_nios_key_debounced

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning input port bit count (legal range 1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive stable cycles required to accept a new level (0 = bypass).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge clk.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port address, input, 3 bits: register select.
REQ-006 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-007 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-008 The block SHALL have port writedata, input, 32 bits: write data.
REQ-009 The block SHALL have port in_port, input, WIDTH bits: asynchronous key/switch inputs.
REQ-010 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 The block SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-012 in_port SHALL pass through a 2-flop synchronizer, giving sync[WIDTH-1:0].
REQ-013 Each bit SHALL have a counter of width clog2(DEBOUNCE_CYCLES+1); it clears when sync equals stable, else increments.
REQ-014 When a bit's counter reaches DEBOUNCE_CYCLES-1 with sync still differing, stable SHALL take the sync value on that edge, and the counter SHALL clear.
REQ-015 With DEBOUNCE_CYCLES=0, stable SHALL equal sync delayed one cycle; no counters are instantiated.
REQ-016 Edge detection SHALL compare stable with its one-cycle-delayed copy stable_d: rise = stable & ~stable_d; fall = ~stable & stable_d.
REQ-017 edge_capture[i] SHALL set when (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]).
REQ-018 Register map (unused upper bits read 0; reads of 6/7 return 0; writes to 0/1/6/7 are ignored): 0 stable (RO), 1 sync raw (RO), 2 irq_mask (RW), 3 edge_capture (R, write-1-to-clear), 4 rise_en (RW), 5 fall_en (RW).
REQ-019 A write SHALL occur when chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used.
REQ-020 Writing 1 to edge_capture bit i SHALL clear it; writing 0 leaves it unchanged.
REQ-021 Simultaneous clear and set of the same bit SHALL leave the bit set (no event lost).
REQ-022 readdata SHALL update every cycle from the address-selected mux, giving 1-cycle read latency, independent of chipselect.
REQ-023 irq SHALL be combinational |(edge_capture & irq_mask).
REQ-024 A change in rise_en/fall_en SHALL affect only edges detected on subsequent cycles; already-captured bits are not altered.

Reset
REQ-025 On reset, the following SHALL clear to 0: readdata, irq, irq_mask, edge_capture, rise_en, all counters, synchronizer flops.
REQ-026 On reset, stable and stable_d SHALL load all-ones (idle keys high), and fall_en SHALL load all-ones, so the default captures key presses.
REQ-027 Reset asserted mid-debounce SHALL abort the count; no edge SHALL be captured from a transition in progress.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-028 Bench: after reset, read addr 5 -> 0x0000000F; addr 0 -> 0x0000000F; addr 3 -> 0; irq=0.
REQ-029 Bench: in_port[0] 1->0 held 10 cycles, irq_mask=0x1 -> stable[0]=0 exactly 2+4 cycles after the change; edge_capture=0x1 one cycle later; irq=1.
REQ-030 Bench: in_port[1] glitches low for 3 cycles, then returns high -> stable unchanged; edge_capture=0.
REQ-031 Bench: edge_capture=0x1, then write 0x1 to addr 3 in the same cycle a new fall on bit 0 is detected -> edge_capture stays 0x1; irq stays 1.
REQ-032 Bench: write rise_en=0x4, fall_en=0; bit2 low->high stable -> edge_capture=0x4; a high->low transition afterwards adds nothing.
REQ-033 Bench: reset pulse 2 cycles into a bit3 debounce -> after reset, stable=0xF, edge_capture=0, irq=0.
